// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target with an 8-bit register-pointer interface.
// Write: START, addr+W, REG byte, data bytes..., STOP.
// Read: pointer set by an earlier write, then (repeated) START, addr+R, data bytes.
// Optional feature: define I2C_SLAVE_AUTOINC_EN to auto-increment the register
// pointer after each data access.
`timescale 1ns/1ps
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_en,
  output logic       o_rd_en,
  input  logic [7:0] i_rd_data,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // Bus line synchronizers and previous-value flops for edge detection
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       rd_cap_q, rd_cap_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;

  // Derived bus events (synchronized domain only)
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_next;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_next   = {rx_sr_q[6:0], sda_s};

  // Open-drain driver: only ever pulls low, and lets go as soon as reset rises
  assign io_sda = (sda_oe_q && !i_rst) ? 1'b0 : 1'bz;

  assign o_reg_addr = reg_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_en    = wr_en_q;
  assign o_rd_en    = rd_en_q;
  assign o_busy     = busy_q;

  // Next values for the synchronizer chains
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], io_sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Synchronizer registers, preset high to match an idle bus
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // Next-state and output logic; START/STOP take priority over every state
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rw_d       = rw_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_cap_d   = rd_en_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    // Read data is valid one cycle after the request
    if (rd_cap_q) begin
      tx_sr_d = i_rd_data;
    end else begin
      tx_sr_d = tx_sr_q;
    end
`ifdef I2C_SLAVE_AUTOINC_EN
    if (wr_en_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end else begin
      reg_addr_d = reg_addr_q;
    end
`else
    reg_addr_d = reg_addr_q;
`endif

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (rx_next[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = rx_next[0];
                rd_en_d = rx_next[0];
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              state_d = ADDR;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else if (rw_q) begin
              state_d   = RDATA;
              sda_oe_d  = ~tx_sr_q[7];
              tx_sr_d   = {tx_sr_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = REG;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            state_d = ADDR_ACK;
          end
        end
        REG: begin
          if (scl_rise) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              reg_addr_d = rx_next;
              state_d    = REG_ACK;
            end else begin
              state_d = REG;
            end
          end else begin
            state_d = REG;
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = WDATA;
              bit_cnt_d = 4'd0;
            end
          end else begin
            state_d = state_q;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              wr_data_d = rx_next;
              wr_en_d   = 1'b1;
              state_d   = WDATA_ACK;
            end else begin
              state_d = WDATA;
            end
          end else begin
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d  = ~tx_sr_q[7];
              tx_sr_d   = {tx_sr_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = RDATA;
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rd_en_d = 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
              reg_addr_d = reg_addr_q + 8'd1;
`endif
            end else begin
              state_d  = IDLE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end else if (scl_fall) begin
            state_d   = RDATA;
            sda_oe_d  = ~tx_sr_q[7];
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d = RDATA_ACK;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Protocol state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      rx_sr_q    <= 8'd0;
      tx_sr_q    <= 8'd0;
      rw_q       <= 1'b0;
      reg_addr_q <= 8'd0;
      wr_data_q  <= 8'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_cap_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rw_q       <= rw_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_cap_q   <= rd_cap_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: bit-banged I2C master with a scoreboard on the
// register-side strobes; ACKs and read bytes are checked by the master.
`timescale 1ns/1ps
module tb_i2c_slave_regif;

  localparam int Q = 80;   // quarter SCL period in ns (SCL = 32 system clocks)

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_oe;
  logic [7:0] rd_data;
  logic [7:0] rd_val;
  wire        sda_bus;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rd_en;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  wr_exp_t    exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_exp_t    wr_e;
  logic       wr_prev;
  logic       rd_prev;

  pullup (sda_bus);
  assign sda_bus = m_oe ? 1'b0 : 1'bz;

  i2c_slave_regif #(.SLAVE_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl),
    .io_sda     (sda_bus),
    .o_reg_addr (reg_addr),
    .o_wr_data  (wr_data),
    .o_wr_en    (wr_en),
    .o_rd_en    (rd_en),
    .i_rd_data  (rd_data),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: read data appears one clock after the request
  always @(posedge clk) rd_data <= rd_en ? rd_val : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        check("wr_en_single_cycle", {31'd0, wr_prev}, 32'd0);
        if (exp_wr.size() == 0) begin
          check("wr_expected_pending", exp_wr.size(), 32'd1);
        end else begin
          wr_e = exp_wr.pop_front();
          check("wr_addr", {24'd0, reg_addr}, {24'd0, wr_e.addr});
          check("wr_data", {24'd0, wr_data}, {24'd0, wr_e.data});
        end
      end
      if (rd_en) begin
        check("rd_en_single_cycle", {31'd0, rd_prev}, 32'd0);
        if (exp_rd.size() == 0) begin
          check("rd_expected_pending", exp_rd.size(), 32'd1);
        end else begin
          check("rd_addr", {24'd0, reg_addr}, {24'd0, exp_rd.pop_front()});
        end
      end
    end
    wr_prev <= wr_en;
    rd_prev <= rd_en;
  end

  task automatic i2c_start();
    m_oe = 1'b0; #(Q); scl = 1'b1; #(Q); m_oe = 1'b1; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; #(Q); scl = 1'b1; #(Q); m_oe = 1'b0; #(Q);
  endtask

  task automatic wbit(input logic b);
    m_oe = ~b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    m_oe = 1'b0; #(Q); scl = 1'b1; #(Q);
    acked = (sda_bus === 1'b0);
    #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    m_oe = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #(Q); scl = 1'b1; #(Q);
      d = {d[6:0], sda_bus};
      #(Q); scl = 1'b0; #(Q);
    end
    m_oe = ~nack; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    m_oe = 1'b0;
  endtask

  // Runaway guard
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  logic       ack;
  logic [7:0] rbuf;

  initial begin
    rst = 1'b1; scl = 1'b1; m_oe = 1'b0; rd_val = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_reg_addr", {24'd0, reg_addr}, 32'h0);
    check("reset_wr_data", {24'd0, wr_data}, 32'h0);
    check("reset_strobes", {30'd0, wr_en, rd_en}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_sda", {31'd0, sda_bus}, 32'h1);

    // Single write: 0x80 into register 0x12
    i2c_start();
    wbyte(8'h42, ack); check("t1_addr_ack", {31'd0, ack}, 32'h1);
    check("t1_busy_high", {31'd0, busy}, 32'h1);
    exp_wr.push_back('{8'h12, 8'h80});
    wbyte(8'h12, ack); check("t1_reg_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h80, ack); check("t1_data_ack", {31'd0, ack}, 32'h1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_busy_after_stop", {31'd0, busy}, 32'h0);

    // Pointer write, repeated START, read one byte with NACK
    rd_val = 8'h76;
    i2c_start();
    wbyte(8'h42, ack); check("t2_addr_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h0A, ack); check("t2_reg_ack", {31'd0, ack}, 32'h1);
    i2c_start();
    exp_rd.push_back(8'h0A);
    wbyte(8'h43, ack); check("t2_raddr_ack", {31'd0, ack}, 32'h1);
    check("t2_busy_in_read", {31'd0, busy}, 32'h1);
    rbyte(1'b1, rbuf);
    check("t2_read_byte", {24'd0, rbuf}, 32'h76);
    check("t2_busy_after_nack", {31'd0, busy}, 32'h0);
    i2c_stop();

    // Foreign address: no ACK, then bytes without START are ignored
    i2c_start();
    wbyte(8'h40, ack); check("t3_foreign_nack", {31'd0, ack}, 32'h0);
    check("t3_busy_low", {31'd0, busy}, 32'h0);
    wbyte(8'h42, ack); check("t3_ignored_addr", {31'd0, ack}, 32'h0);
    wbyte(8'h12, ack); check("t3_ignored_byte", {31'd0, ack}, 32'h0);
    i2c_stop();

    // STOP after half a data byte: no write, pointer kept
    i2c_start();
    wbyte(8'h42, ack); check("t4_addr_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h12, ack); check("t4_reg_ack", {31'd0, ack}, 32'h1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t4_busy_low", {31'd0, busy}, 32'h0);
    check("t4_sda_released", {31'd0, sda_bus}, 32'h1);
    check("t4_pointer_kept", {24'd0, reg_addr}, 32'h12);

    // Two data bytes from pointer 0xFF
    exp_wr.push_back('{8'hFF, 8'h11});
`ifdef I2C_SLAVE_AUTOINC_EN
    exp_wr.push_back('{8'h00, 8'h22});
`else
    exp_wr.push_back('{8'hFF, 8'h22});
`endif
    i2c_start();
    wbyte(8'h42, ack); check("t5_addr_ack", {31'd0, ack}, 32'h1);
    wbyte(8'hFF, ack); check("t5_reg_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h11, ack); check("t5_d0_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h22, ack); check("t5_d1_ack", {31'd0, ack}, 32'h1);
    i2c_stop();
    repeat (4) @(negedge clk);

    // Reset while the address ACK is on the bus
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(((8'h42 >> i) & 8'h01) != 8'h00);
    m_oe = 1'b0; #(Q); scl = 1'b1; #(Q);
    check("t6_ack_driven", {31'd0, sda_bus}, 32'h0);
    rst = 1'b1;
    #1;
    check("t6_sda_released", {31'd0, sda_bus}, 32'h1);
    check("t6_reg_addr", {24'd0, reg_addr}, 32'h0);
    check("t6_wr_data", {24'd0, wr_data}, 32'h0);
    check("t6_strobes", {30'd0, wr_en, rd_en}, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'h0);
    #(Q-1); scl = 1'b0; #(Q);
    @(negedge clk);
    rst = 1'b0;
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t6_busy_after", {31'd0, busy}, 32'h0);

    // Fresh transaction after reset
    exp_wr.push_back('{8'h33, 8'h5A});
    i2c_start();
    wbyte(8'h42, ack); check("t7_addr_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h33, ack); check("t7_reg_ack", {31'd0, ack}, 32'h1);
    wbyte(8'h5A, ack); check("t7_data_ack", {31'd0, ack}, 32'h1);
    i2c_stop();
    repeat (10) @(negedge clk);

    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
